// File: rtl/counter_pkg.sv
// ============================================================================
// counter_pkg
// Shared types and configuration checks for the counter family.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_pkg;

  // Run/park state of a modulo counter
  typedef enum logic {
    CNT_RUN  = 1'b0,
    CNT_DONE = 1'b1
  } cnt_state_t;

  // Smallest meaningful modulus
  localparam int MIN_MODULUS = 2;

  // Returns 1 when the parameter set describes a usable counter
  function automatic bit counter_cfg_ok(input int width, input int modulus,
                                        input int decode_val);
    counter_cfg_ok = (modulus >= MIN_MODULUS) &&
                     ((64'd1 << width) >= 64'(modulus)) &&
                     (decode_val >= 0) && (decode_val < modulus);
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter_step.sv
// ============================================================================
// counter_step
// Combinational next-count for a modulo counter: steps by +/-1, or wraps to
// the opposite end of the range when the current value is terminal.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_step #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  input  logic             terminal,
  output logic [WIDTH-1:0] next_count
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

  // Wrap is decided from the terminal flag, never from arithmetic overflow
  always_comb begin
    next_count = count;
    if (terminal) begin
      next_count = up_dn ? '0 : MAX_COUNT;
    end else if (up_dn) begin
      next_count = count + WIDTH'(1);
    end else begin
      next_count = count - WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mod_counter_decoder.sv
// ============================================================================
// mod_counter_decoder
// Parametrised modulo counter with value decode, up/down direction, one-shot
// parking and optional parallel load.
// Build option: define COUNTER_LOAD_EN to build the parallel load path;
// otherwise load/load_val are present but ignored.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_counter_decoder
  import counter_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int MODULUS    = 8,
  parameter int DECODE_VAL = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stop,
  input  logic             up_dn,
  input  logic             oneshot,
  input  logic             start,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_out,
  output logic             decode_out,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] DEC_COUNT = WIDTH'(DECODE_VAL);
  // A misconfigured instance never raises decode_out
  localparam bit               CFG_OK    = counter_cfg_ok(WIDTH, MODULUS, DECODE_VAL);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] load_sat;
  logic             load_req;
  logic             terminal;
  cnt_state_t       state;
  cnt_state_t       state_next;

  // Terminal depends on the live direction input
  assign terminal = up_dn ? (count_reg == MAX_COUNT) : (count_reg == '0);

`ifdef COUNTER_LOAD_EN
  assign load_req = load;
  assign load_sat = (load_val > MAX_COUNT) ? MAX_COUNT : load_val;
`else
  logic unused_load;
  assign unused_load = ^{load, load_val};
  assign load_req    = 1'b0;
  assign load_sat    = '0;
`endif

  counter_step #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_step (
    .count      (count_reg),
    .up_dn      (up_dn),
    .terminal   (terminal),
    .next_count (stepped)
  );

  // State and count registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      state     <= CNT_RUN;
    end else begin
      count_reg <= count_next;
      state     <= state_next;
    end
  end

  // Next-state / next-count: load > stop > start > advance
  always_comb begin
    count_next = count_reg;
    state_next = state;
    if (load_req) begin
      count_next = load_sat;
      state_next = CNT_RUN;
    end else if (stop) begin
      count_next = count_reg;
      state_next = state;
    end else begin
      case (state)
        CNT_DONE: begin
          if (start) begin
            count_next = up_dn ? '0 : MAX_COUNT;
            state_next = CNT_RUN;
          end
        end
        default: begin
          if (terminal && oneshot) begin
            state_next = CNT_DONE;
          end else begin
            count_next = stepped;
          end
        end
      endcase
    end
  end

  assign count_out  = count_reg;
  assign decode_out = CFG_OK && (count_reg == DEC_COUNT);
  assign tc         = terminal;
  assign done       = (state == CNT_DONE);

endmodule

`default_nettype wire

// File: tb/tb_mod_counter_decoder.sv
// ============================================================================
// tb_mod_counter_decoder
// Directed vector bench for mod_counter_decoder at WIDTH=4, MODULUS=8,
// DECODE_VAL=2.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_counter_decoder;

  logic       clk;
  logic       reset;
  logic       stop;
  logic       up_dn;
  logic       oneshot;
  logic       start;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] count_out;
  logic       decode_out;
  logic       tc;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       stop;
    logic       up_dn;
    logic       oneshot;
    logic       start;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] exp_count;
    logic       exp_dec;
    logic       exp_tc;
    logic       exp_done;
  } vec_t;

  vec_t vecs[$];

  mod_counter_decoder #(
    .WIDTH      (4),
    .MODULUS    (8),
    .DECODE_VAL (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stop       (stop),
    .up_dn      (up_dn),
    .oneshot    (oneshot),
    .start      (start),
    .load       (load),
    .load_val   (load_val),
    .count_out  (count_out),
    .decode_out (decode_out),
    .tc         (tc),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int c, input int d, input int t, input int dn);
    chk({name, ".count"}, int'(count_out), c);
    chk({name, ".decode"}, int'(decode_out), d);
    chk({name, ".tc"}, int'(tc), t);
    chk({name, ".done"}, int'(done), dn);
  endtask

  // Decode and tc expectations follow directly from count and direction
  task automatic add(input logic s, input logic u, input logic o, input logic st,
                     input logic ld, input logic [3:0] lv, input logic [3:0] c,
                     input logic dn);
    vec_t v;
    v.stop = s; v.up_dn = u; v.oneshot = o; v.start = st;
    v.load = ld; v.load_val = lv; v.exp_count = c; v.exp_done = dn;
    v.exp_dec = (c == 4'd2);
    v.exp_tc  = u ? (c == 4'd7) : (c == 4'd0);
    vecs.push_back(v);
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stop = 1'b0; up_dn = 1'b1; oneshot = 1'b0; start = 1'b0;
    load = 1'b0; load_val = 4'd0;
  endtask

  initial begin
    // free-run up: 1..7,0,1,2
    add(0,1,0,0,0,0, 4'd1,0); add(0,1,0,0,0,0, 4'd2,0);
    add(0,1,0,0,0,0, 4'd3,0); add(0,1,0,0,0,0, 4'd4,0);
    add(0,1,0,0,0,0, 4'd5,0); add(0,1,0,0,0,0, 4'd6,0);
    add(0,1,0,0,0,0, 4'd7,0); add(0,1,0,0,0,0, 4'd0,0);
    add(0,1,0,0,0,0, 4'd1,0); add(0,1,0,0,0,0, 4'd2,0);
    // reach 3, then stop with start pulses for 4 edges, then release
    add(0,1,0,0,0,0, 4'd3,0);
    add(1,1,0,1,0,0, 4'd3,0); add(1,1,0,1,0,0, 4'd3,0);
    add(1,1,0,1,0,0, 4'd3,0); add(1,1,0,1,0,0, 4'd3,0);
    add(0,1,0,0,0,0, 4'd4,0);
    // count down with wrap 0 -> 7, then switch to up at 4
    add(0,0,0,0,0,0, 4'd3,0); add(0,0,0,0,0,0, 4'd2,0);
    add(0,0,0,0,0,0, 4'd1,0); add(0,0,0,0,0,0, 4'd0,0);
    add(0,0,0,0,0,0, 4'd7,0); add(0,0,0,0,0,0, 4'd6,0);
    add(0,0,0,0,0,0, 4'd5,0); add(0,0,0,0,0,0, 4'd4,0);
    add(0,1,0,0,0,0, 4'd5,0);
    // one-shot up: park at 7, hold, restart to 0
    add(0,1,1,0,0,0, 4'd6,0); add(0,1,1,0,0,0, 4'd7,0);
    add(0,1,1,0,0,0, 4'd7,1); add(0,1,1,0,0,0, 4'd7,1);
    add(0,1,1,1,0,0, 4'd0,0);
    // start while running has no effect
    add(0,1,1,1,0,0, 4'd1,0);
    // one-shot down: park at 0, stop blocks start, restart to 7
    add(0,0,1,0,0,0, 4'd0,0); add(0,0,1,0,0,0, 4'd0,1);
    add(1,0,1,1,0,0, 4'd0,1);
    add(0,0,1,1,0,0, 4'd7,0);
    // load strobe: taken only when the load path is built
`ifdef COUNTER_LOAD_EN
    add(0,0,0,0,1,4'd5, 4'd5,0);
`else
    add(0,0,0,0,1,4'd5, 4'd6,0);
`endif

    idle_inputs();
    reset = 1'b1;
    #3;
    chk_all("reset_up", 0, 0, 0, 0);
    up_dn = 1'b0;
    #1;
    chk("reset_down.tc", int'(tc), 1);
    up_dn = 1'b1;
    #8;
    reset = 1'b0;   // t=12, first counting edge at t=15
    chk_all("reset_held_edge", 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      stop = vecs[i].stop; up_dn = vecs[i].up_dn; oneshot = vecs[i].oneshot;
      start = vecs[i].start; load = vecs[i].load; load_val = vecs[i].load_val;
      edge_step();
      chk_all($sformatf("vec%0d", i), int'(vecs[i].exp_count), int'(vecs[i].exp_dec),
              int'(vecs[i].exp_tc), int'(vecs[i].exp_done));
    end
    idle_inputs();

`ifdef COUNTER_LOAD_EN
    // load during stop, saturating load, load out of DONE
    stop = 1'b1; load = 1'b1; load_val = 4'd5;
    edge_step();
    chk_all("load_stop", 5, 0, 0, 0);
    stop = 1'b0; load_val = 4'd12;
    edge_step();
    chk_all("load_sat", 7, 0, 1, 0);
    load = 1'b0; oneshot = 1'b1;
    edge_step();
    chk_all("load_park", 7, 0, 1, 1);
    load = 1'b1; load_val = 4'd3;
    edge_step();
    chk_all("load_from_done", 3, 0, 0, 0);
    idle_inputs();
`endif

    // drive into DONE via one-shot up, bounded
    oneshot = 1'b1;
    for (int i = 0; i < 12 && !done; i++) edge_step();
    chk_all("park_before_reset", 7, 0, 1, 1);

    // asynchronous reset between edges, with a pending start
    #2;
    reset = 1'b1; start = 1'b1;
    #1;
    chk_all("async_reset", 0, 0, 0, 0);
    edge_step();
    chk_all("reset_ignores_start", 0, 0, 0, 0);
    #3;
    reset = 1'b0; start = 1'b0; oneshot = 1'b0;
    edge_step();
    chk_all("resume_after_reset", 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
